// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter; ports clk/rst/tick, wr_en+dados_transmissao push, tx line, txBusy/txFull/txEmpty/txCount/txOverflow status
module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               tick,
  input  logic                               wr_en,
  input  logic [DATA_BITS-1:0]               dados_transmissao,
  output logic                               tx,
  output logic                               txBusy,
  output logic                               txFull,
  output logic                               txEmpty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    txCount,
  output logic                               txOverflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int BW = $clog2(DATA_BITS+1);
  typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} state_t;
  state_t               state;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [DATA_BITS-1:0] shift;
  logic [AW-1:0]        wptr, rptr;
  logic [BW-1:0]        bcnt;
  logic                 scnt, par, push, pop;
  assign txFull  = txCount == CW'(FIFO_DEPTH);
  assign txEmpty = txCount == '0;
  assign txBusy  = state != IDLE || !txEmpty;
  assign push    = wr_en && !txFull;
  assign pop     = tick && state == IDLE && !txEmpty;
  always_ff @(posedge clk)
    if (push) mem[wptr] <= dados_transmissao;
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tx         <= 1'b1;
      wptr       <= '0;
      rptr       <= '0;
      txCount    <= '0;
      txOverflow <= 1'b0;
      shift      <= '0;
      bcnt       <= '0;
      scnt       <= 1'b0;
      par        <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      txCount <= txCount + CW'(push) - CW'(pop);
      if (wr_en && txFull) txOverflow <= 1'b1;
      if (tick)
        case (state)
          IDLE: if (!txEmpty) begin
            shift <= mem[rptr];
            tx    <= 1'b0;
            bcnt  <= '0;
            par   <= 1'b0;
            state <= DATA;
          end
          DATA: begin
            tx    <= shift[0];
            shift <= shift >> 1;
            par   <= par ^ shift[0];
            bcnt  <= bcnt + 1'b1;
            if (bcnt == BW'(DATA_BITS-1)) begin
              scnt  <= 1'b0;
              state <= PARITY != 0 ? PAR : STOP;
            end
          end
          PAR: begin
            tx    <= PARITY == 2 ? par : ~par;
            state <= STOP;
          end
          default: begin
            tx <= 1'b1;
            if (scnt == 1'(STOP_BITS-1)) state <= IDLE;
            else scnt <= 1'b1;
          end
        endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: vector table, directed frame sequences and randomized model comparison for uart_tx_fifo
module tb_uart_tx_fifo;
  logic clk = 0, rst = 1, tick = 0, wr_en = 0;
  logic [7:0] din = 0;
  logic tx0, busy0, full0, empty0, ovf0;
  logic tx1, busy1, full1, empty1, ovf1;
  logic tx2, busy2, full2, empty2, ovf2;
  logic [2:0] cnt0, cnt1, cnt2;
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  uart_tx_fifo u0 (
    .clk(clk), .rst(rst), .tick(tick), .wr_en(wr_en), .dados_transmissao(din),
    .tx(tx0), .txBusy(busy0), .txFull(full0), .txEmpty(empty0), .txCount(cnt0), .txOverflow(ovf0)
  );
  uart_tx_fifo #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u1 (
    .clk(clk), .rst(rst), .tick(tick), .wr_en(wr_en), .dados_transmissao(din[6:0]),
    .tx(tx1), .txBusy(busy1), .txFull(full1), .txEmpty(empty1), .txCount(cnt1), .txOverflow(ovf1)
  );
  uart_tx_fifo #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u2 (
    .clk(clk), .rst(rst), .tick(tick), .wr_en(wr_en), .dados_transmissao(din[6:0]),
    .tx(tx2), .txBusy(busy2), .txFull(full2), .txEmpty(empty2), .txCount(cnt2), .txOverflow(ovf2)
  );
  int mq[$];
  int fb[$];
  logic m_tx = 1, m_ovf = 0;
  task automatic model(input logic r, t, w, input logic [7:0] d);
    bit was_full;
    int x;
    was_full = mq.size() == 4;
    if (r) begin
      mq.delete();
      fb.delete();
      m_tx = 1;
      m_ovf = 0;
    end else begin
      if (t) begin
        if (fb.size() != 0) m_tx = fb.pop_front()[0];
        else if (mq.size() != 0) begin
          x = mq.pop_front();
          m_tx = 0;
          for (int i = 0; i < 8; i++) fb.push_back((x >> i) & 1);
          fb.push_back(1);
        end
      end
      if (w) begin
        if (was_full) m_ovf = 1;
        else mq.push_back(int'(d));
      end
    end
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic cyc(input logic r, t, w, input logic [7:0] d);
    rst = r; tick = t; wr_en = w; din = d;
    model(r, t, w, d);
    @(negedge clk);
  endtask
  task automatic frame_bits(input logic [7:0] w, inout int q[$]);
    q.push_back(0);
    for (int i = 0; i < 8; i++) q.push_back(int'(w[i]));
    q.push_back(1);
  endtask
  typedef struct {
    logic r, t, w;
    logic [7:0] d;
    logic [7:0] e;
  } vec_t;
  vec_t tbl[10];
  int ex[$];
  logic [9:0] e55;
  logic [10:0] e_even, e_odd;
  logic [7:0] act, exp;
  logic [7:0] wds[3];
  initial begin
    tbl = '{
      '{1'b1, 1'b0, 1'b0, 8'h00, 8'b1001_0000},
      '{1'b0, 1'b0, 1'b1, 8'h11, 8'b1100_0001},
      '{1'b0, 1'b1, 1'b1, 8'h22, 8'b0100_0001},
      '{1'b1, 1'b0, 1'b0, 8'h00, 8'b1001_0000},
      '{1'b0, 1'b1, 1'b1, 8'hA0, 8'b1100_0001},
      '{1'b0, 1'b0, 1'b1, 8'hA1, 8'b1100_0010},
      '{1'b0, 1'b0, 1'b1, 8'hA2, 8'b1100_0011},
      '{1'b0, 1'b0, 1'b1, 8'hA3, 8'b1110_0100},
      '{1'b0, 1'b0, 1'b1, 8'hEE, 8'b1110_1100},
      '{1'b0, 1'b1, 1'b1, 8'hEE, 8'b0100_1011}
    };
    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].r, tbl[i].t, tbl[i].w, tbl[i].d);
      chk($sformatf("vec%0d", i), {tx0, busy0, full0, empty0, ovf0, cnt0}, tbl[i].e);
    end
    ex.delete();
    for (int i = 0; i < 8; i++) ex.push_back(int'(((8'hA0) >> i) & 8'h01));
    ex.push_back(1);
    frame_bits(8'hA1, ex);
    frame_bits(8'hA2, ex);
    frame_bits(8'hA3, ex);
    ex.push_back(1);
    ex.push_back(1);
    for (int i = 0; i < ex.size(); i++) begin
      cyc(0, 1, 0, 0);
      chk($sformatf("drain_tx%0d", i), tx0, ex[i]);
      cyc(0, 0, 0, 0);
    end
    chk("ovf_sticky", ovf0, 1);
    chk("drain_busy", busy0, 0);
    chk("drain_empty", empty0, 1);
    cyc(1, 0, 0, 0);
    chk("rst_ovf", ovf0, 0);
    cyc(0, 1, 1, 8'h55);
    chk("coinc_tx", tx0, 1);
    chk("coinc_busy", busy0, 1);
    chk("coinc_cnt", cnt0, 1);
    e55 = 10'h2AA;
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, 0, 0);
      chk($sformatf("f55_tx%0d", i), tx0, e55[i]);
      chk($sformatf("f55_busy%0d", i), busy0, i < 9);
      for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0);
    end
    cyc(0, 1, 0, 0);
    chk("f55_idle", tx0, 1);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 8'h03);
    e_even = 11'h606;
    e_odd  = 11'h706;
    for (int i = 0; i < 11; i++) begin
      cyc(0, 1, 0, 0);
      chk($sformatf("even_tx%0d", i), tx1, e_even[i]);
      chk($sformatf("odd_tx%0d", i), tx2, e_odd[i]);
      cyc(0, 0, 0, 0);
    end
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 0, 0);
      cyc(0, 0, 0, 0);
    end
    chk("par_busy_even", busy1, 0);
    chk("par_busy_odd", busy2, 0);
    cyc(1, 0, 0, 0);
    wds = '{8'hA1, 8'hB2, 8'hC3};
    ex.delete();
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 1, wds[k]);
      chk($sformatf("b2b_cnt%0d", k), cnt0, k + 1);
      frame_bits(wds[k], ex);
    end
    for (int i = 0; i < 30; i++) begin
      cyc(0, 1, 0, 0);
      chk($sformatf("b2b_tx%0d", i), tx0, ex[i]);
      cyc(0, 0, 0, 0);
    end
    chk("b2b_busy", busy0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 8'h00);
    cyc(0, 0, 1, 8'h11);
    cyc(0, 0, 1, 8'h22);
    cyc(0, 0, 1, 8'h33);
    cyc(0, 0, 1, 8'h44);
    chk("mid_ovf_set", ovf0, 1);
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0);
    chk("mid_bit3", tx0, 0);
    cyc(1, 1, 0, 0);
    chk("mid_rst_tx", tx0, 1);
    chk("mid_rst_cnt", cnt0, 0);
    chk("mid_rst_busy", busy0, 0);
    chk("mid_rst_ovf", ovf0, 0);
    for (int i = 0; i < 40; i++) begin
      cyc(0, 1, 0, 0);
      chk("mid_quiet", {tx0, busy0}, 2'b10);
    end
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 2) == 0,
          ((i / 500) % 2 == 0) ? $urandom_range(0, 3) == 0 : $urandom_range(0, 39) == 0,
          8'($urandom));
      act = {tx0, busy0, full0, empty0, ovf0, cnt0};
      exp = {m_tx, logic'(fb.size() != 0 || mq.size() != 0), logic'(mq.size() == 4),
             logic'(mq.size() == 0), m_ovf, 3'(mq.size())};
      chk($sformatf("rand%0d", i), act, exp);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
